// File: rtl/motor_pkg.sv
// motor_pkg: shared widths and FSM state encoding for the divide arbiter
package motor_pkg;
    localparam int NUMERATOR_W   = 64;
    localparam int DENOMINATOR_W = 32;
    localparam int QUOTIENT_W    = 32;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/round_robin_select.sv
// round_robin_select: picks the first requester after last_i, wrapping, with last_i itself lowest priority
module round_robin_select #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);
    // scan offsets from farthest to nearest so the nearest active requester wins
    always_comb begin
        valid_o = 1'b0;
        idx_o   = last_i;
        for (int j = N_REQ; j >= 1; j--) begin
            if (req_i[IDX_W'((int'(last_i) + j) % N_REQ)]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'((int'(last_i) + j) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/divide_arbiter.sv
// divide_arbiter: round-robin sharing of one fixed-latency Divide core; DIVIDE_ARBITER_DIV_ZERO_BYPASS_EN short-circuits zero denominators
module divide_arbiter
    import motor_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 34
) (
    input  logic                             Clk,
    input  logic                             nReset,
    input  logic [N_REQ-1:0]                 Req,
    input  logic [N_REQ*NUMERATOR_W-1:0]     Numerator,
    input  logic [N_REQ*DENOMINATOR_W-1:0]   Denominator,
    output logic [N_REQ-1:0]                 Done,
    output logic [QUOTIENT_W-1:0]            Quotient,
    output logic                             DivZero,
    output logic                             Busy,
    output logic [NUMERATOR_W-1:0]           Div_Numerator,
    output logic [DENOMINATOR_W-1:0]         Div_Denominator,
    input  logic [QUOTIENT_W-1:0]            Div_Quotient
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

    state_e                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic [N_REQ-1:0]         done_q, done_d;
    logic [QUOTIENT_W-1:0]    quot_q, quot_d;
    logic                     dz_q, dz_d;
    logic [NUMERATOR_W-1:0]   num_q, num_d;
    logic [DENOMINATOR_W-1:0] den_q, den_d;

    logic                     gnt_valid;
    logic [IDX_W-1:0]         gnt_idx;
    logic [NUMERATOR_W-1:0]   sel_num;
    logic [DENOMINATOR_W-1:0] sel_den;
    logic                     bypass;

    round_robin_select #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i   (Req),
        .last_i  (last_q),
        .valid_o (gnt_valid),
        .idx_o   (gnt_idx)
    );

    assign sel_num = Numerator[int'(gnt_idx)*NUMERATOR_W +: NUMERATOR_W];
    assign sel_den = Denominator[int'(gnt_idx)*DENOMINATOR_W +: DENOMINATOR_W];

`ifdef DIVIDE_ARBITER_DIV_ZERO_BYPASS_EN
    assign bypass = sel_den == '0;
`else
    assign bypass = 1'b0;
`endif

    assign Done            = done_q;
    assign Quotient        = quot_q;
    assign DivZero         = dz_q;
    assign Busy            = state_q != IDLE;
    assign Div_Numerator   = num_q;
    assign Div_Denominator = den_q;

    // grant in IDLE, count core latency in RUN, pulse Done for one cycle in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        done_d  = done_q;
        quot_d  = quot_q;
        dz_d    = dz_q;
        num_d   = num_q;
        den_d   = den_q;
        if (state_q == IDLE) begin
            if (gnt_valid) begin
                last_d = gnt_idx;
                cnt_d  = '0;
                if (bypass) begin
                    state_d = DONE;
                    done_d  = N_REQ'(1) << gnt_idx;
                    quot_d  = '1;
                    dz_d    = 1'b1;
                end else begin
                    state_d = RUN;
                    num_d   = sel_num;
                    den_d   = sel_den;
                end
            end
        end else if (state_q == RUN) begin
            if (cnt_q == LAST_CNT) begin
                state_d = DONE;
                done_d  = Req[last_q] ? N_REQ'(1) << last_q : '0;
                quot_d  = Req[last_q] ? Div_Quotient : quot_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            state_d = IDLE;
            done_d  = '0;
            dz_d    = 1'b0;
        end
    end

    // state registers; last index resets to N_REQ-1 so requester 0 wins first
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            done_q  <= '0;
            quot_q  <= '0;
            dz_q    <= 1'b0;
            num_q   <= '0;
            den_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            dz_q    <= dz_d;
            num_q   <= num_d;
            den_q   <= den_d;
        end
    end
endmodule

// File: tb/tb_divide_arbiter.sv
// tb_divide_arbiter: directed scoreboard bench for divide_arbiter with a combinational Divide core model
module tb_divide_arbiter;
    localparam int N = 4;
    localparam int LAT = 34;

    typedef struct {
        logic [N-1:0] done;
        logic [31:0]  q;
        logic         dz;
    } exp_t;

    logic            Clk;
    logic            nReset;
    logic [N-1:0]    Req;
    logic [N*64-1:0] Numerator;
    logic [N*32-1:0] Denominator;
    logic [N-1:0]    Done;
    logic [31:0]     Quotient;
    logic            DivZero;
    logic            Busy;
    logic [63:0]     Div_Numerator;
    logic [31:0]     Div_Denominator;
    logic [31:0]     Div_Quotient;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    exp_t sb[$];

    divide_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
        .Clk             (Clk),
        .nReset          (nReset),
        .Req             (Req),
        .Numerator       (Numerator),
        .Denominator     (Denominator),
        .Done            (Done),
        .Quotient        (Quotient),
        .DivZero         (DivZero),
        .Busy            (Busy),
        .Div_Numerator   (Div_Numerator),
        .Div_Denominator (Div_Denominator),
        .Div_Quotient    (Div_Quotient)
    );

    function automatic logic [31:0] core_f(input logic [63:0] n, input logic [31:0] d);
        return (n == 64'h1000_0000_0000 && d == 32'd1000) ? 32'h0000_0041 : n[31:0] ^ n[63:32] ^ d;
    endfunction

    assign Div_Quotient = core_f(Div_Numerator, Div_Denominator);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] num_of(input int i);
        return Numerator[i*64 +: 64];
    endfunction

    function automatic logic [31:0] den_of(input int i);
        return Denominator[i*32 +: 32];
    endfunction

    task automatic push(input int i);
        exp_t e;
        e.done = N'(1) << i;
        e.q    = core_f(num_of(i), den_of(i));
        e.dz   = 1'b0;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (Done === '0 && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_sb_has_entry"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_done"}, 64'(Done), 64'(e.done));
            chk({tag, "_quotient"}, 64'(Quotient), 64'(e.q));
            chk({tag, "_divzero"}, 64'(DivZero), 64'(e.dz));
        end
        last_done_cyc = cyc;
    endtask

    initial begin
        int          order[5];
        int          prev_done;
        logic        saw_done;
        logic [31:0] q_prev;
        exp_t        e;
        order = '{0, 1, 2, 3, 0};
        nReset = 1'b0;
        Req = '0;
        Numerator = '0;
        Denominator = '0;
        // reset state
        step();
        step();
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_quotient", 64'(Quotient), 64'd0);
        chk("rst_divzero", 64'(DivZero), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_div_num", Div_Numerator, 64'd0);
        chk("rst_div_den", 64'(Div_Denominator), 64'd0);
        nReset = 1'b1;
        step();
        step();
        chk("idle_no_req_busy", 64'(Busy), 64'd0);
        // single request from requester 0
        Numerator[0 +: 64] = 64'h1000_0000_0000;
        Denominator[0 +: 32] = 32'd1000;
        Req = 4'b0001;
        push(0);
        step();
        chk("t1_busy", 64'(Busy), 64'd1);
        chk("t1_div_num", Div_Numerator, 64'h1000_0000_0000);
        chk("t1_div_den", 64'(Div_Denominator), 64'd1000);
        wait_done("t1", LAT - 1 + 1);
        chk("t1_q41", 64'(Quotient), 64'h41);
        Req = '0;
        step();
        chk("t1_done_clear", 64'(Done), 64'd0);
        chk("t1_idle", 64'(Busy), 64'd0);
        chk("t1_q_hold", 64'(Quotient), 64'h41);
        chk("t1_dz_low", 64'(DivZero), 64'd0);
        // round robin with all requesters active
        for (int i = 0; i < N; i++) begin
            Numerator[i*64 +: 64] = {32'h1111_1111 * (i + 1), 32'hA5A5_0000 + 32'(i)};
            Denominator[i*32 +: 32] = 32'd7 + 32'(i);
        end
        nReset = 1'b0;
        #1;
        nReset = 1'b1;
        Req = '1;
        push(0);
        step();
        chk("rr_grant0", Div_Numerator, num_of(0));
        prev_done = -1;
        for (int o = 0; o < 5; o++) begin
            wait_done($sformatf("rr%0d", o), LAT);
            if (prev_done >= 0) chk($sformatf("rr%0d_spacing", o), 64'(cyc - prev_done), 64'd36);
            prev_done = last_done_cyc;
            step();
            if (o == 4) begin
                Req = '0;
            end else begin
                Req[order[o]] = 1'b0;
                push(order[o + 1]);
                step();
                Req[order[o]] = 1'b1;
                chk($sformatf("rr%0d_next_grant", o), Div_Numerator, num_of(order[o + 1]));
            end
        end
        step();
        chk("rr_idle", 64'(Busy), 64'd0);
        q_prev = core_f(num_of(0), den_of(0));
        // granted requester drops mid-run
        Req = 4'b0100;
        step();
        chk("drop_grant2", Div_Numerator, num_of(2));
        for (int i = 0; i < 9; i++) step();
        Req = '0;
        saw_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            saw_done |= Done != '0;
        end
        chk("drop_in_done_state", 64'(Busy), 64'd1);
        step();
        saw_done |= Done != '0;
        chk("drop_idle_k36", 64'(Busy), 64'd0);
        chk("drop_no_done", 64'(saw_done), 64'd0);
        chk("drop_q_kept", 64'(Quotient), 64'(q_prev));
        // reset mid-run
        Req = 4'b0001;
        step();
        chk("rstrun_busy", 64'(Busy), 64'd1);
        for (int i = 0; i < 19; i++) step();
        nReset = 1'b0;
        #1;
        chk("rstrun_busy0", 64'(Busy), 64'd0);
        chk("rstrun_done0", 64'(Done), 64'd0);
        chk("rstrun_q0", 64'(Quotient), 64'd0);
        chk("rstrun_num0", Div_Numerator, 64'd0);
        chk("rstrun_den0", 64'(Div_Denominator), 64'd0);
        step();
        step();
        Req = 4'b0010;
        nReset = 1'b1;
        push(1);
        step();
        chk("rstrun_grant1", Div_Numerator, num_of(1));
        wait_done("rstrun", LAT);
        Req = '0;
        step();
        // zero denominator
        Denominator[3*32 +: 32] = 32'd0;
        Req = 4'b1000;
`ifdef DIVIDE_ARBITER_DIV_ZERO_BYPASS_EN
        e.done = 4'b1000;
        e.q = 32'hFFFF_FFFF;
        e.dz = 1'b1;
        sb.push_back(e);
        step();
        chk("dz_busy", 64'(Busy), 64'd1);
        chk("dz_num_kept", Div_Numerator, num_of(1));
        chk("dz_den_kept", 64'(Div_Denominator), 64'(den_of(1)));
        wait_done("dz", 0);
`else
        push(3);
        step();
        chk("dz_den_to_core", 64'(Div_Denominator), 64'd0);
        chk("dz_num_to_core", Div_Numerator, num_of(3));
        wait_done("dz", LAT);
`endif
        Req = '0;
        step();
        chk("dz_idle", 64'(Busy), 64'd0);
        chk("dz_cleared", 64'(DivZero), 64'd0);
        // new request raised during the DONE cycle
        Req = 4'b0001;
        push(0);
        step();
        chk("late_grant0", Div_Numerator, num_of(0));
        wait_done("late0", LAT);
        Req = 4'b0011;
        step();
        chk("late_done_edge_idle", 64'(Busy), 64'd0);
        chk("late_done_edge_num", Div_Numerator, num_of(0));
        Req = 4'b0010;
        push(1);
        step();
        chk("late_grant1_busy", 64'(Busy), 64'd1);
        chk("late_grant1_num", Div_Numerator, num_of(1));
        wait_done("late1", LAT);
        Req = '0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            saw_done |= Done != '0;
        end
        chk("late_no_dup_done", 64'(saw_done), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
